tone_player: RTL and testbench

- Parametrised key-to-tone player for the speaker path.
- Accepts one key code per valid/ready handshake and latches an octave with it.
- Plays the note as a square wave for a programmable duration, then enforces a silent gap before the next key is accepted.
- Generalises the fixed-table, fixed-octave music block: adds a selectable octave, note duration, rests, abort, and an optional PWM volume.

---
 rtl/tone_pkg.sv | 34 +++
 rtl/tone_divider.sv | 42 ++++
 rtl/tone_player.sv | 120 ++++++++++++
 tb/tb_tone_player.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared types and tables for the tone player: FSM states, semitone divisors, octave prescaler.
package tone_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  localparam logic [3:0] REST_MIN = 4'd12;

  // Full divisor D for semitones A..G#; rests keep a valid divisor so the counters still run.
  function automatic logic [9:0] note_div(input logic [3:0] code);
    logic [9:0] d;
    case (code)
      4'd0:    d = 10'd512;
      4'd1:    d = 10'd483;
      4'd2:    d = 10'd456;
      4'd3:    d = 10'd431;
      4'd4:    d = 10'd406;
      4'd5:    d = 10'd384;
      4'd6:    d = 10'd362;
      4'd7:    d = 10'd342;
      4'd8:    d = 10'd323;
      4'd9:    d = 10'd304;
      4'd10:   d = 10'd287;
      4'd11:   d = 10'd271;
      default: d = 10'd512;
    endcase
    return d;
  endfunction

  // 2^(7-octave) - 1
  function automatic logic [6:0] pre_reload(input logic [2:0] oct);
    return 7'h7F >> oct;
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: toggles once every (div+1)*(pre+1) cycles while clear is low.
// Latency: first toggle (div+1)*(pre+1) cycles after clear drops; no backpressure.
module tone_divider #(
  parameter int DIV_W = 9,
  parameter int PRE_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  input  logic [PRE_W-1:0] pre,
  input  logic             mute,
  output logic             sq
);

  logic [DIV_W-1:0] note_cnt;
  logic [PRE_W-1:0] pre_cnt;
  logic             note_wrap;
  logic             pre_wrap;

  // Up-counters from zero give the same toggle timing as reloading and counting down.
  assign note_wrap = (note_cnt == div);
  assign pre_wrap  = (pre_cnt == pre);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_cnt <= '0;
      pre_cnt  <= '0;
      sq       <= 1'b0;
    end else if (clear) begin
      note_cnt <= '0;
      pre_cnt  <= '0;
      sq       <= 1'b0;
    end else begin
      note_cnt <= note_wrap ? '0 : note_cnt + 1'b1;
      if (note_wrap)
        pre_cnt <= pre_wrap ? '0 : pre_cnt + 1'b1;
      sq <= mute ? 1'b0 : (sq ^ (note_wrap & pre_wrap));
    end
  end

endmodule

// File: rtl/tone_player.sv
// Key-to-tone player: one key per handshake, plays NOTE_DUR cycles then stays silent GAP_DUR cycles;
// key_ready only in IDLE holds the source off. TONE_PLAYER_VOLUME_EN adds a 3-bit PWM volume input.
module tone_player
  import tone_pkg::*;
#(
  parameter int DUR_W    = 24,
  parameter int NOTE_DUR = 6000000,
  parameter int GAP_DUR  = 600000,
  parameter int DIV_W    = 9,
  parameter int PRE_W    = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic [2:0] octave,
  output logic       key_ready,
  input  logic       stop,
  output logic       busy,
  output logic [3:0] cur_key,
`ifdef TONE_PLAYER_VOLUME_EN
  input  logic [2:0] vol,
`endif
  output logic       speaker
);

  localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_DUR - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'(GAP_DUR - 1);

  state_t           state, state_nx;
  logic [DUR_W-1:0] timer;
  logic [DIV_W-1:0] div_q;
  logic [PRE_W-1:0] pre_q;
  logic             rest_q;
  logic             accept;
  logic             timer_done;
  logic             playing;
  logic             sq;

  assign key_ready  = (state == IDLE);
  assign busy       = !key_ready;
  assign playing    = (state == PLAY);
  assign accept     = key_valid && key_ready && !stop;
  assign timer_done = (timer == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)     state_nx = PLAY;
      PLAY:    if (timer_done) state_nx = GAP;
      GAP:     if (timer_done) state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
    if (stop) state_nx = IDLE;
  end

  // One timer serves both the note duration and the following gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer   <= '0;
      div_q   <= '0;
      pre_q   <= '0;
      rest_q  <= 1'b0;
      cur_key <= '0;
    end else if (stop) begin
      timer <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          timer   <= NOTE_LAST;
          div_q   <= DIV_W'(note_div(key_code) - 10'd1);
          pre_q   <= PRE_W'(pre_reload(octave));
          rest_q  <= (key_code >= REST_MIN);
          cur_key <= key_code;
        end
        PLAY:    timer <= timer_done ? GAP_LAST : timer - 1'b1;
        GAP:     if (!timer_done) timer <= timer - 1'b1;
        default: timer <= '0;
      endcase
    end
  end

  tone_divider #(
    .DIV_W (DIV_W),
    .PRE_W (PRE_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!playing || stop),
    .div   (div_q),
    .pre   (pre_q),
    .mute  (rest_q),
    .sq    (sq)
  );

`ifdef TONE_PLAYER_VOLUME_EN
  logic [2:0] pwm;
  logic [2:0] vol_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm   <= '0;
      vol_q <= '0;
    end else begin
      pwm <= pwm + 1'b1;
      if (accept) vol_q <= vol;
    end
  end

  assign speaker = sq && playing && (pwm < vol_q);
`else
  assign speaker = sq && playing;
`endif

endmodule

// File: tb/tb_tone_player.sv
// Scoreboard bench: predicted (cycle, speaker, busy) change events are queued per DUT and matched on change.
module tb_tone_player;
  import tone_pkg::*;

  localparam int N0 = 20000;
  localparam int N1 = 200000;
  localparam int G  = 100;
`ifdef TONE_PLAYER_VOLUME_EN
  localparam bit SPK_ON = 1'b0;
`else
  localparam bit SPK_ON = 1'b1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n = 1'b0, rst1_n = 1'b0;
  logic       kv0 = 1'b0, kv1 = 1'b0, stop0 = 1'b0, stop1 = 1'b0;
  logic [3:0] kc0 = '0, kc1 = '0;
  logic [2:0] oct0 = '0, oct1 = '0;
  logic       rdy0, rdy1, busy0, busy1, spk0, spk1;
  logic [3:0] ck0, ck1;
`ifdef TONE_PLAYER_VOLUME_EN
  logic [2:0] vol0 = '0, vol1 = '0;
`endif

  tone_player #(.NOTE_DUR(N0), .GAP_DUR(G)) dut0 (
    .clk(clk), .rst_n(rst0_n), .key_valid(kv0), .key_code(kc0), .octave(oct0),
    .key_ready(rdy0), .stop(stop0), .busy(busy0), .cur_key(ck0),
`ifdef TONE_PLAYER_VOLUME_EN
    .vol(vol0),
`endif
    .speaker(spk0));

  tone_player #(.NOTE_DUR(N1), .GAP_DUR(G)) dut1 (
    .clk(clk), .rst_n(rst1_n), .key_valid(kv1), .key_code(kc1), .octave(oct1),
    .key_ready(rdy1), .stop(stop1), .busy(busy1), .cur_key(ck1),
`ifdef TONE_PLAYER_VOLUME_EN
    .vol(vol1),
`endif
    .speaker(spk1));

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int q0[$];
  int q1[$];
  logic [1:0] prev0 = 2'b00, prev1 = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input int d, input int v);
    if (d == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  // Event code = cycle*4 + speaker*2 + busy. stop_c != 0 means the note is cut at that edge.
  task automatic play_model(input int d, input int a, input int div, input int pre,
                            input bit rest, input int n, input int stop_c);
    int half, end_c;
    bit sp;
    half  = div * (pre + 1);
    end_c = (stop_c != 0) ? stop_c : a + n;
    sp    = 1'b0;
    push_ev(d, a * 4 + 1);
    if (!rest && SPK_ON)
      for (int t = half; a + t < end_c; t += half) begin
        sp = ~sp;
        push_ev(d, (a + t) * 4 + (sp ? 3 : 1));
      end
    if (stop_c != 0) push_ev(d, end_c * 4);
    else begin
      if (sp) push_ev(d, end_c * 4 + 1);
      push_ev(d, (end_c + G) * 4);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if ({spk0, busy0} != prev0) begin
      if (q0.size() == 0) check("dut0_extra_evt", cyc * 4 + {spk0, busy0}, -1);
      else                check("dut0_evt", cyc * 4 + {spk0, busy0}, q0.pop_front());
      prev0 = {spk0, busy0};
    end
    if ({spk1, busy1} != prev1) begin
      if (q1.size() == 0) check("dut1_extra_evt", cyc * 4 + {spk1, busy1}, -1);
      else                check("dut1_evt", cyc * 4 + {spk1, busy1}, q1.pop_front());
      prev1 = {spk1, busy1};
    end
  end

  task automatic main_seq();
    int a, b, r, c;
    repeat (3) @(negedge clk);
    check("rst_ready", rdy0, 1);
    check("rst_busy", busy0, 0);
    check("rst_speaker", spk0, 0);
    check("rst_cur_key", ck0, 0);
    rst0_n = 1'b1;
    // Key 11 octave 7, then key 5 held through PLAY/GAP and later cut by stop
    @(negedge clk); kv0 = 1'b1; kc0 = 4'd11; oct0 = 3'd7;
    @(posedge clk); #1;
    a = cyc;
    b = a + N0 + G + 1;
    play_model(0, a, 271, 0, 1'b0, N0, 0);
    play_model(0, b, 384, 15, 1'b0, N0, b + 7000);
    check("ready_in_play", rdy0, 0);
    check("cur_key_11", ck0, 11);
    kc0 = 4'd5; oct0 = 3'd3;
    wait_cyc(b);
    check("cur_key_5", ck0, 5);
    kv0 = 1'b0;
    wait_cyc(b + 6999);
    stop0 = 1'b1;
    @(posedge clk); #1;
    stop0 = 1'b0;
    check("stop_ready", rdy0, 1);
    check("stop_speaker", spk0, 0);
    // stop beats accept in IDLE
    @(negedge clk); kv0 = 1'b1; kc0 = 4'd2; stop0 = 1'b1;
    @(posedge clk); #1;
    check("stopacc_ready", rdy0, 1);
    check("stopacc_busy", busy0, 0);
    @(negedge clk); kv0 = 1'b0; stop0 = 1'b0;
    // Rest: silent but same occupancy
    @(negedge clk); kv0 = 1'b1; kc0 = 4'd13; oct0 = 3'd4;
    @(posedge clk); #1;
    r = cyc;
    kv0 = 1'b0;
    play_model(0, r, 512, 7, 1'b1, N0, 0);
    wait_cyc(r + N0 + G + 2);
    // Async reset mid-note
    @(negedge clk); kv0 = 1'b1; kc0 = 4'd0; oct0 = 3'd7;
    @(posedge clk); #1;
    c = cyc;
    kv0 = 1'b0;
    play_model(0, c, 512, 0, 1'b0, N0, c + 600);
    wait_cyc(c + 599);
    @(posedge clk); #2;
    rst0_n = 1'b0;
    #1;
    check("arst_speaker", spk0, 0);
    check("arst_ready", rdy0, 1);
    check("arst_busy", busy0, 0);
    repeat (2) @(negedge clk);
    rst0_n = 1'b1;
  endtask

  task automatic long_seq();
    int l;
    repeat (3) @(negedge clk);
    rst1_n = 1'b1;
    @(negedge clk); kv1 = 1'b1; kc1 = 4'd0; oct1 = 3'd0;
    @(posedge clk); #1;
    l = cyc;
    kv1 = 1'b0;
    check("long_cur_key", ck1, 0);
    play_model(1, l, 512, 127, 1'b0, N1, l + 66000);
    wait_cyc(l + 65999);
    stop1 = 1'b1;
    @(posedge clk); #1;
    stop1 = 1'b0;
    check("long_stop_speaker", spk1, 0);
    check("long_stop_ready", rdy1, 1);
  endtask

  initial begin
    fork
      main_seq();
      long_seq();
    join
    repeat (10) @(negedge clk);
    check("dut0_pending", q0.size(), 0);
    check("dut1_pending", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
